// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem req/ready handshake, IF/ID register and redirect handling.
// Optional feature: define FETCH_PERF_CNT_EN to add the fetch_cnt load counter output.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [1:0]  pc_sel,
   input  logic [31:0] branch_target,
   input  logic [31:0] jump_target,
   input  logic [31:0] jr_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc4,
   output logic [25:0] ifid_addr26,
   output logic        ifid_valid
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt
`endif
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {IDLE, BUSY, HOLD, REDIR} state_t;

   state_t            state;
   logic [XLEN-1:0]   hold_instr;
   logic [XLEN-1:0]   redir_pc;
   logic [XLEN-1:0]   pc4;
   logic [XLEN-1:0]   target;
   logic [XLEN-1:0]   ld_instr;
   logic [XLEN-1:0]   ld_pc4;
   logic              redirect;
   logic              ld_en;

   assign redirect    = (pc_sel != 2'b00);
   assign pc4         = pc + XLEN'(4);
   assign imem_addr   = pc;
   assign imem_req    = (state == BUSY) || (state == REDIR);
   assign ifid_addr26 = ifid_instr[25:0];

   always_comb begin
      target = branch_target;
      case (pc_sel)
         2'b10:   target = jump_target;
         2'b11:   target = jr_target;
         default: target = branch_target;
      endcase
   end

   // In HOLD the PC has already advanced past the held word, so pc is its PC+4.
   always_comb begin
      ld_en    = 1'b0;
      ld_instr = imem_rdata;
      ld_pc4   = pc4;
      case (state)
         BUSY: ld_en = imem_ready && !redirect && !stall_i;
         HOLD: begin
            ld_en    = !redirect && !stall_i;
            ld_instr = hold_instr;
            ld_pc4   = pc;
         end
         default: ld_en = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         hold_instr <= '0;
         redir_pc   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (redirect) pc <= target;
               state <= stall_i ? IDLE : BUSY;
            end
            BUSY: begin
               if (imem_ready) begin
                  if (redirect) begin
                     pc <= target;
                  end else begin
                     pc <= pc4;
                     if (stall_i) begin
                        hold_instr <= imem_rdata;
                        state      <= HOLD;
                     end
                  end
               end else if (redirect) begin
                  redir_pc <= target;
                  state    <= REDIR;
               end
            end
            HOLD: begin
               if (redirect) begin
                  pc    <= target;
                  state <= IDLE;
               end else if (!stall_i) begin
                  state <= BUSY;
               end
            end
            REDIR: begin
               // A redirect arriving with the completing word supersedes the buffered one.
               if (imem_ready) begin
                  pc    <= redirect ? target : redir_pc;
                  state <= stall_i ? IDLE : BUSY;
               end else if (redirect) begin
                  redir_pc <= target;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ifid_valid <= 1'b0;
         ifid_instr <= '0;
         ifid_pc4   <= '0;
      end else if (flush_i) begin
         ifid_valid <= 1'b0;
      end else if (stall_i) begin
         ifid_valid <= ifid_valid;
      end else if (ld_en) begin
         ifid_valid <= 1'b1;
         ifid_instr <= ld_instr;
         ifid_pc4   <= ld_pc4;
      end else begin
         ifid_valid <= 1'b0;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_cnt <= '0;
      end else if (ld_en && !flush_i) begin
         fetch_cnt <= fetch_cnt + XLEN'(1);
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: scoreboard of expected IF/ID loads plus per-scenario checks.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        stall_i;
   logic        flush_i;
   logic [1:0]  pc_sel;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic [31:0] jr_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc4;
   logic [25:0] ifid_addr26;
   logic        ifid_valid;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt;
`endif

   int total;
   int bad;
   logic [63:0] exp_q[$];
   logic [63:0] e;
   logic [31:0] ea;

   fetch_stage #(.RESET_PC(32'h0040_0000)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall_i),
      .flush_i       (flush_i),
      .pc_sel        (pc_sel),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .jr_target     (jr_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .pc            (pc),
      .ifid_instr    (ifid_instr),
      .ifid_pc4      (ifid_pc4),
      .ifid_addr26   (ifid_addr26),
      .ifid_valid    (ifid_valid)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt     (fetch_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   // Advance one clock, then present the memory word for the new address.
   task automatic tick();
      @(posedge clk);
      #1;
      imem_rdata = mem_word(imem_addr);
   endtask

   task automatic test_reset();
      rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0; pc_sel = 2'b00;
      branch_target = '0; jump_target = '0; jr_target = '0;
      imem_ready = 1'b1; imem_rdata = '0;
      tick(); tick();
      total++; if (pc !== 32'h0040_0000) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0040_0000); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
      total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
      total++; if (ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0) begin bad++; $display("FAIL reset_ifid got=%h/%h exp=0/0", ifid_instr, ifid_pc4); end
   endtask

   task automatic test_zero_wait();
      rst = 1'b1;
      tick();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000 || ifid_valid !== 1'b0) begin
         bad++; $display("FAIL first_req got=%b/%h/%b exp=1/00400000/0", imem_req, imem_addr, ifid_valid); end
      ea = 32'h0040_0000;
      for (int i = 0; i < 4; i++) begin
         total++; if (imem_addr !== ea) begin bad++; $display("FAIL seq_addr got=%h exp=%h", imem_addr, ea); end
         exp_q.push_back({mem_word(ea), ea + 32'd4});
         tick();
         e = exp_q.pop_front();
         total++; if (ifid_valid !== 1'b1 || ifid_instr !== e[63:32] || ifid_pc4 !== e[31:0]) begin
            bad++; $display("FAIL seq_load got=%b/%h/%h exp=1/%h/%h", ifid_valid, ifid_instr, ifid_pc4, e[63:32], e[31:0]); end
         ea = ea + 32'd4;
      end
   endtask

   task automatic test_jump();
      pc_sel = 2'b10; jump_target = 32'h0040_0100;
      tick();
      pc_sel = 2'b00;
      total++; if (imem_addr !== 32'h0040_0100 || ifid_valid !== 1'b0) begin
         bad++; $display("FAIL jump_redir got=%h/%b exp=00400100/0", imem_addr, ifid_valid); end
      ea = 32'h0040_0100;
      exp_q.push_back({mem_word(ea), ea + 32'd4});
      tick();
      e = exp_q.pop_front();
      total++; if (ifid_valid !== 1'b1 || ifid_instr !== e[63:32] || ifid_pc4 !== e[31:0]) begin
         bad++; $display("FAIL jump_load got=%b/%h/%h exp=1/%h/%h", ifid_valid, ifid_instr, ifid_pc4, e[63:32], e[31:0]); end
      ea = ea + 32'd4;
   endtask

   task automatic test_wait_redirect();
      imem_ready = 1'b0; pc_sel = 2'b01; branch_target = 32'h0040_0040;
      for (int i = 0; i < 3; i++) begin
         tick();
         pc_sel = 2'b00;
         total++; if (imem_addr !== ea || imem_req !== 1'b1 || ifid_valid !== 1'b0) begin
            bad++; $display("FAIL wait_hold_addr got=%h/%b/%b exp=%h/1/0", imem_addr, imem_req, ifid_valid, ea); end
      end
      imem_ready = 1'b1;
      tick();
      total++; if (imem_addr !== 32'h0040_0040 || ifid_valid !== 1'b0) begin
         bad++; $display("FAIL wait_redir got=%h/%b exp=00400040/0", imem_addr, ifid_valid); end
      ea = 32'h0040_0040;
      exp_q.push_back({mem_word(ea), ea + 32'd4});
      tick();
      e = exp_q.pop_front();
      total++; if (ifid_valid !== 1'b1 || ifid_instr !== e[63:32] || ifid_pc4 !== e[31:0]) begin
         bad++; $display("FAIL wait_load got=%b/%h/%h exp=1/%h/%h", ifid_valid, ifid_instr, ifid_pc4, e[63:32], e[31:0]); end
      ea = ea + 32'd4;
   endtask

   task automatic test_stall();
      imem_rdata = 32'h8C08_0004; stall_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++; if (ifid_valid !== 1'b1 || ifid_instr !== mem_word(32'h0040_0040) || ifid_pc4 !== 32'h0040_0044 || imem_req !== 1'b0) begin
            bad++; $display("FAIL stall_hold got=%b/%h/%h/%b exp=1/%h/00400044/0", ifid_valid, ifid_instr, ifid_pc4, imem_req, mem_word(32'h0040_0040)); end
      end
      stall_i = 1'b0;
      exp_q.push_back({32'h8C08_0004, ea + 32'd4});
      tick();
      e = exp_q.pop_front();
      total++; if (ifid_valid !== 1'b1 || ifid_instr !== e[63:32] || ifid_pc4 !== e[31:0]) begin
         bad++; $display("FAIL stall_release got=%b/%h/%h exp=1/%h/%h", ifid_valid, ifid_instr, ifid_pc4, e[63:32], e[31:0]); end
      ea = ea + 32'd4;
      total++; if (imem_addr !== ea || imem_req !== 1'b1) begin bad++; $display("FAIL stall_resume got=%h/%b exp=%h/1", imem_addr, imem_req, ea); end
      exp_q.push_back({mem_word(ea), ea + 32'd4});
      tick();
      e = exp_q.pop_front();
      total++; if (ifid_valid !== 1'b1 || ifid_instr !== e[63:32] || ifid_pc4 !== e[31:0]) begin
         bad++; $display("FAIL stall_next got=%b/%h/%h exp=1/%h/%h", ifid_valid, ifid_instr, ifid_pc4, e[63:32], e[31:0]); end
      ea = ea + 32'd4;
   endtask

   task automatic test_flush_stall();
      flush_i = 1'b1; stall_i = 1'b1;
      tick();
      flush_i = 1'b0; stall_i = 1'b0;
      total++; if (ifid_valid !== 1'b0 || ifid_instr !== mem_word(ea - 32'd4)) begin
         bad++; $display("FAIL flush_stall got=%b/%h exp=0/%h", ifid_valid, ifid_instr, mem_word(ea - 32'd4)); end
      exp_q.push_back({mem_word(ea), ea + 32'd4});
      tick();
      e = exp_q.pop_front();
      total++; if (ifid_valid !== 1'b1 || ifid_instr !== e[63:32] || ifid_pc4 !== e[31:0]) begin
         bad++; $display("FAIL flush_release got=%b/%h/%h exp=1/%h/%h", ifid_valid, ifid_instr, ifid_pc4, e[63:32], e[31:0]); end
   endtask

   task automatic test_wrap();
      pc_sel = 2'b11; jr_target = 32'hFFFF_FFFC;
      tick();
      pc_sel = 2'b00;
      total++; if (imem_addr !== 32'hFFFF_FFFC || ifid_valid !== 1'b0) begin
         bad++; $display("FAIL jr_redir got=%h/%b exp=fffffffc/0", imem_addr, ifid_valid); end
      exp_q.push_back({mem_word(32'hFFFF_FFFC), 32'h0});
      tick();
      e = exp_q.pop_front();
      total++; if (ifid_valid !== 1'b1 || ifid_instr !== e[63:32] || ifid_pc4 !== e[31:0]) begin
         bad++; $display("FAIL wrap_load got=%b/%h/%h exp=1/%h/%h", ifid_valid, ifid_instr, ifid_pc4, e[63:32], e[31:0]); end
      total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h exp=00000000", imem_addr); end
   endtask

   task automatic test_hold_redirect();
      stall_i = 1'b1;
      tick();
      stall_i = 1'b0; pc_sel = 2'b01; branch_target = 32'h0040_0200;
      tick();
      pc_sel = 2'b00;
      total++; if (ifid_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0040_0200) begin
         bad++; $display("FAIL hold_redir got=%b/%b/%h exp=0/0/00400200", ifid_valid, imem_req, imem_addr); end
      tick();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0200 || ifid_valid !== 1'b0) begin
         bad++; $display("FAIL hold_refetch got=%b/%h/%b exp=1/00400200/0", imem_req, imem_addr, ifid_valid); end
      exp_q.push_back({mem_word(32'h0040_0200), 32'h0040_0204});
      tick();
      e = exp_q.pop_front();
      total++; if (ifid_valid !== 1'b1 || ifid_instr !== e[63:32] || ifid_pc4 !== e[31:0]) begin
         bad++; $display("FAIL hold_load got=%b/%h/%h exp=1/%h/%h", ifid_valid, ifid_instr, ifid_pc4, e[63:32], e[31:0]); end
   endtask

   task automatic test_reset_mid();
      imem_ready = 1'b0; pc_sel = 2'b01; branch_target = 32'h0040_0300;
      tick();
      pc_sel = 2'b00;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0204) begin
         bad++; $display("FAIL redir_pending got=%b/%h exp=1/00400204", imem_req, imem_addr); end
      rst = 1'b0; imem_ready = 1'b1;
      tick();
      total++; if (pc !== 32'h0040_0000 || imem_req !== 1'b0 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0) begin
         bad++; $display("FAIL mid_reset got=%h/%b/%b/%h/%h exp=00400000/0/0/0/0", pc, imem_req, ifid_valid, ifid_instr, ifid_pc4); end
      rst = 1'b1;
      tick();
      total++; if (imem_addr !== 32'h0040_0000 || imem_req !== 1'b1) begin
         bad++; $display("FAIL mid_restart got=%h/%b exp=00400000/1", imem_addr, imem_req); end
   endtask

`ifdef FETCH_PERF_CNT_EN
   task automatic test_perf_cnt();
      rst = 1'b0;
      tick();
      total++; if (fetch_cnt !== 32'd0) begin bad++; $display("FAIL cnt_reset got=%0d exp=0", fetch_cnt); end
      rst = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         flush_i = (i == 4);
         tick();
      end
      flush_i = 1'b0;
      total++; if (fetch_cnt !== 32'd9) begin bad++; $display("FAIL cnt_value got=%0d exp=9", fetch_cnt); end
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_zero_wait();
      test_jump();
      test_wait_redirect();
      test_stall();
      test_flush_stall();
      test_wrap();
      test_hold_redirect();
      test_reset_mid();
`ifdef FETCH_PERF_CNT_EN
      test_perf_cnt();
`endif
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
